// File: rtl/twiddle_seq.sv
// ============================================================================
// twiddle_seq: streams the 16 twiddles W16^e for one radix-2 DIF FFT stage.
// Revision 1.0
// ============================================================================
`default_nettype none

module twiddle_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int F_W        = 14
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [1:0]                   stage,
  input  logic                         inv,
  output logic                         busy,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] w_r,
  output logic signed [DATA_WIDTH-1:0] w_i,
  output logic [3:0]                   out_idx,
  output logic                         out_last,
  output logic                         done
);

  // Elaboration-time only: converts a 2^30-scaled value to Q(F_W), rounding
  // half away from zero and clipping to the output range.
  function automatic logic signed [DATA_WIDTH-1:0] fx(input longint m);
    longint a, r, mx, mn;
    int     sh;
    sh = 30 - F_W;
    a  = (m < 0) ? -m : m;
    if (sh > 0) r = (a + (64'sd1 <<< (sh - 1))) >>> sh;
    else        r = a <<< (-sh);
    if (m < 0) r = -r;
    mx = (64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1;
    mn = -(64'sd1 <<< (DATA_WIDTH - 1));
    if (r > mx)      r = mx;
    else if (r < mn) r = mn;
    return r[DATA_WIDTH-1:0];
  endfunction

  function automatic logic [2:0] exp_of(input logic [3:0] k, input logic [1:0] s);
    logic [4:0] half, p, t;
    half = 5'd8 >> s;
    p    = {1'b0, k} & ((half << 1) - 5'd1);
    t    = (p < half) ? 5'd0 : ((p - half) << s);
    return t[2:0];
  endfunction

  localparam longint c_one = 64'sd1073741824;  // 1.0
  localparam longint c_c1  = 64'sd992008094;   // cos(pi/8)
  localparam longint c_h   = 64'sd759250125;   // sqrt(2)/2
  localparam longint c_s1  = 64'sd410903207;   // sin(pi/8)

  localparam logic signed [DATA_WIDTH-1:0] c_cos [8] = '{
    fx(c_one), fx(c_c1), fx(c_h), fx(c_s1), fx(64'sd0), fx(-c_s1), fx(-c_h), fx(-c_c1)};
  localparam logic signed [DATA_WIDTH-1:0] c_sin_pos [8] = '{
    fx(64'sd0), fx(c_s1), fx(c_h), fx(c_c1), fx(c_one), fx(c_c1), fx(c_h), fx(c_s1)};
  localparam logic signed [DATA_WIDTH-1:0] c_sin_neg [8] = '{
    fx(64'sd0), fx(-c_s1), fx(-c_h), fx(-c_c1), fx(-c_one), fx(-c_c1), fx(-c_h), fx(-c_s1)};

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              stage_q, stage_d;
  logic                    inv_q, inv_d;
  logic [3:0]              k_q, k_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic                    done_q, done_d;
  logic signed [DATA_WIDTH-1:0] w_r_q, w_r_d, w_i_q, w_i_d;
  logic                    load_tw;
  logic [2:0]              e_d;

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    inv_d   = inv_q;
    k_d     = k_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    w_r_d   = w_r_q;
    w_i_d   = w_i_q;
    load_tw = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          stage_d = stage;
          inv_d   = inv;
          k_d     = 4'd0;
          valid_d = 1'b1;
          load_tw = 1'b1;
        end
      end
      ST_RUN: begin
        if (valid_q && out_ready) begin
          if (k_q == 4'd15) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            k_d     = k_q + 4'd1;
            load_tw = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Twiddle for the index that will be presented next cycle.
    e_d = exp_of(k_d, stage_d);
    if (load_tw) begin
      w_r_d = c_cos[e_d];
      w_i_d = inv_d ? c_sin_pos[e_d] : c_sin_neg[e_d];
    end
    last_d = valid_d & (k_d == 4'd15);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      stage_q <= 2'd0;
      inv_q   <= 1'b0;
      k_q     <= 4'd0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      w_r_q   <= '0;
      w_i_q   <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      inv_q   <= inv_d;
      k_q     <= k_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      w_r_q   <= w_r_d;
      w_i_q   <= w_i_d;
    end
  end

  assign busy      = valid_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign out_idx   = k_q;
  assign w_r       = w_r_q;
  assign w_i       = w_i_q;
  assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_twiddle_seq.sv
// ============================================================================
// tb_twiddle_seq: directed checks of the twiddle stream against hand values.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_twiddle_seq;

  logic clk = 1'b0;
  logic rst_n;
  logic start, inv, out_ready;
  logic [1:0] stage;
  logic busy, out_valid, out_last, done;
  logic signed [15:0] w_r, w_i;
  logic [3:0] out_idx;

  logic start2, inv2, out_ready2;
  logic [1:0] stage2;
  logic busy2, out_valid2, out_last2, done2;
  logic signed [15:0] w_r2, w_i2;
  logic [3:0] out_idx2;

  int n_cmp = 0;
  int n_err = 0;
  int wr_seen [16];
  int wi_seen [16];
  int dcyc, hs, nd;

  always #5 clk = ~clk;

  twiddle_seq #(.DATA_WIDTH(16), .F_W(14)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stage(stage), .inv(inv),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .w_r(w_r), .w_i(w_i), .out_idx(out_idx), .out_last(out_last), .done(done));

  twiddle_seq #(.DATA_WIDTH(16), .F_W(15)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .stage(stage2), .inv(inv2),
    .busy(busy2), .out_valid(out_valid2), .out_ready(out_ready2),
    .w_r(w_r2), .w_i(w_i2), .out_idx(out_idx2), .out_last(out_last2), .done(done2));

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Launches one sequence and records every twiddle by index; with tgl set,
  // out_ready follows 1,0,0,1,0,0... over the valid cycles.
  task automatic run(input logic [1:0] stg, input logic iv, input bit tgl,
                     output int done_cyc, output int n_hs, output int n_done);
    int j, p_idx, p_wr, p_wi;
    bit stalled;
    done_cyc = -1; n_hs = 0; n_done = 0; j = 0; stalled = 0;
    p_idx = 0; p_wr = 0; p_wi = 0;
    for (int k = 0; k < 16; k++) begin
      wr_seen[k] = 99999;
      wi_seen[k] = 99999;
    end
    stage = stg; inv = iv; start = 1'b1; out_ready = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      tick;
      start = 1'b0;
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (out_valid) begin
        if (stalled) begin
          chk("hold_idx", int'(out_idx), p_idx);
          chk("hold_wr", int'(w_r), p_wr);
          chk("hold_wi", int'(w_i), p_wi);
        end else begin
          chk("idx_seq", int'(out_idx), n_hs);
          chk("last", int'(out_last), int'(n_hs == 15));
        end
        wr_seen[out_idx] = int'(w_r);
        wi_seen[out_idx] = int'(w_i);
        p_idx = int'(out_idx); p_wr = int'(w_r); p_wi = int'(w_i);
        out_ready = tgl ? (j % 3 == 0) : 1'b1;
        j++;
        stalled = !out_ready;
        if (out_ready) n_hs++;
      end else begin
        out_ready = 1'b0;
      end
      if (done_cyc > 0 && c >= done_cyc + 2) break;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stage = 2'd0; inv = 1'b0; out_ready = 1'b0;
    start2 = 1'b0; stage2 = 2'd0; inv2 = 1'b0; out_ready2 = 1'b1;
    tick;
    tick;
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_last", int'(out_last), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_wr", int'(w_r), 0);
    chk("rst_wi", int'(w_i), 0);
    chk("rst_idx", int'(out_idx), 0);
    rst_n = 1'b1;
    tick;

    // Q1.15 instance: C(0) clips to the positive maximum
    start2 = 1'b1;
    tick;
    start2 = 1'b0;
    chk("fw15_valid", int'(out_valid2), 1);
    chk("fw15_wr_k0", int'(w_r2), 32767);
    chk("fw15_wi_k0", int'(w_i2), 0);

    // stage 0, forward, always ready
    run(2'd0, 1'b0, 1'b0, dcyc, hs, nd);
    chk("s0_done_cycle", dcyc, 17);
    chk("s0_handshakes", hs, 16);
    chk("s0_done_pulses", nd, 1);
    for (int k = 0; k < 8; k++) begin
      chk("s0_wr_k0to7", wr_seen[k], 16384);
      chk("s0_wi_k0to7", wi_seen[k], 0);
    end
    chk("s0_wr_k9", wr_seen[9], 15137);
    chk("s0_wi_k9", wi_seen[9], -6270);
    chk("s0_wr_k15", wr_seen[15], -15137);
    chk("s0_wi_k15", wi_seen[15], -6270);
    chk("s0_idle_busy", int'(busy), 0);

    // stage 1, forward
    run(2'd1, 1'b0, 1'b0, dcyc, hs, nd);
    chk("s1_wr_k6", wr_seen[6], 0);
    chk("s1_wi_k6", wi_seen[6], -16384);
    chk("s1_wr_k14", wr_seen[14], 0);
    chk("s1_wi_k14", wi_seen[14], -16384);
    chk("s1_wr_k5", wr_seen[5], 11585);
    chk("s1_wi_k5", wi_seen[5], -11585);

    // stage 3, both directions: every twiddle is unity
    for (int d = 0; d < 2; d++) begin
      run(2'd3, d[0], 1'b0, dcyc, hs, nd);
      chk("s3_handshakes", hs, 16);
      for (int k = 0; k < 16; k++) begin
        chk("s3_wr", wr_seen[k], 16384);
        chk("s3_wi", wi_seen[k], 0);
      end
    end

    // stage 0, inverse, back-pressure
    run(2'd0, 1'b1, 1'b1, dcyc, hs, nd);
    chk("bp_handshakes", hs, 16);
    chk("bp_done_pulses", nd, 1);
    chk("bp_wr_k12", wr_seen[12], 0);
    chk("bp_wi_k12", wi_seen[12], 16384);
    chk("bp_wr_k9", wr_seen[9], 15137);
    chk("bp_wi_k9", wi_seen[9], 6270);

    // start mid-sequence is ignored; stage 2 k=7 gives e=4
    stage = 2'd2; inv = 1'b0; start = 1'b1; out_ready = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 20 && out_idx != 4'd5; i++) tick;
    chk("mid_reach_k5", int'(out_idx), 5);
    stage = 2'd0; inv = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    chk("mid_idx_k6", int'(out_idx), 6);
    chk("mid_busy", int'(busy), 1);
    tick;
    chk("mid_idx_k7", int'(out_idx), 7);
    chk("mid_wr_k7", int'(w_r), 0);
    chk("mid_wi_k7", int'(w_i), -16384);
    for (int i = 0; i < 20 && !done; i++) tick;
    chk("mid_done", int'(done), 1);

    // start in the done cycle is accepted
    stage = 2'd1; inv = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    chk("dc_valid", int'(out_valid), 1);
    chk("dc_idx", int'(out_idx), 0);
    chk("dc_busy", int'(busy), 1);
    for (int i = 0; i < 20 && out_idx != 4'd7; i++) tick;
    chk("dc_reach_k7", int'(out_idx), 7);
    chk("dc_wr_k7", int'(w_r), -11585);
    chk("dc_wi_k7", int'(w_i), -11585);

    // reset mid-sequence aborts without done
    rst_n = 1'b0;
    tick;
    chk("ab_valid", int'(out_valid), 0);
    chk("ab_busy", int'(busy), 0);
    chk("ab_wr", int'(w_r), 0);
    chk("ab_wi", int'(w_i), 0);
    chk("ab_done", int'(done), 0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("ab_done_after", int'(done), 0);
    chk("ab_valid_after", int'(out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
